// File: rtl/mult_req_bridge.sv
// -----------------------------------------------------------------------------
// mult_req_bridge
//   Issue stage in front of a signed 16x16 multiplier that uses a req/ack
//   handshake. Operand pairs arrive on a valid/ready source and are buffered
//   in a small FIFO. Each pair is issued with its argument parity. The product
//   and the error flags are returned on a valid/ready sink. A watchdog aborts
//   any request that goes unacknowledged for too long.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                operand source handshake
//   in_arg_a, in_arg_b               signed operands
//   in_inj_par_err                   invert arg_a_parity for this pair
//   arg_a/_parity, arg_b/_parity     operands and parities to the multiplier
//   req / ack                        request to the multiplier, one-cycle ack
//   result, result_parity            product and its parity from the multiplier
//   arg_parity_error                 multiplier saw bad argument parity
//   out_valid/out_ready              response sink handshake
//   out_result, out_arg_perr,
//   out_res_perr, out_timeout        captured response fields
// -----------------------------------------------------------------------------
module mult_req_bridge #(
  parameter int FIFO_DEPTH  = 4,   // power of 2, >= 2
  parameter int TIMEOUT_CYC = 64   // >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_arg_a,
  input  logic [15:0] in_arg_b,
  input  logic        in_inj_par_err,
  output logic [15:0] arg_a,
  output logic        arg_a_parity,
  output logic [15:0] arg_b,
  output logic        arg_b_parity,
  output logic        req,
  input  logic        ack,
  input  logic [31:0] result,
  input  logic        result_parity,
  input  logic        arg_parity_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_arg_perr,
  output logic        out_res_perr,
  output logic        out_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  // The injection bit travels with its operands so it applies to exactly
  // the pair it was offered with.
  typedef struct packed {
    logic        inj;
    logic [15:0] a;
    logic [15:0] b;
  } fifo_word_t;

  fifo_word_t       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  fifo_word_t       head;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  // ---------------------------------------------------------------------------
  // Operand FIFO
  // ---------------------------------------------------------------------------
  assign in_ready = (count_q != FULL_COUNT);
  assign push     = in_valid & in_ready;
  // out_valid is never set in IDLE, so the guard keeps issue and response
  // strictly alternating even if the FSM is extended later.
  assign pop      = (state_q == ST_IDLE) && (count_q != '0) && !out_valid;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: assigning a default first means every path drives count_d, so no latch is inferred.
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is not reset; the count and pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_inj_par_err, in_arg_a, in_arg_b};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;  // wraps because depth is 2^PTR_W
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue / response FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req          <= 1'b0;
      arg_a        <= '0;
      arg_b        <= '0;
      arg_a_parity <= 1'b0;
      arg_b_parity <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_arg_perr <= 1'b0;
      out_res_perr <= 1'b0;
      out_timeout  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            arg_a        <= head.a;
            arg_b        <= head.b;
            arg_a_parity <= (^head.a) ^ head.inj;
            arg_b_parity <= ^head.b;
            req          <= 1'b1;
            cnt_q        <= '0;
            state_q      <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (ack) begin
            out_result   <= result;
            out_arg_perr <= arg_parity_error;
            out_res_perr <= result_parity ^ (^result);
            out_timeout  <= 1'b0;
            out_valid    <= 1'b1;
            req          <= 1'b0;
            state_q      <= ST_RESP;
          end else if (cnt_q == LAST_CNT) begin
            // Watchdog abort: req has been high for TIMEOUT_CYC cycles.
            out_result   <= '0;
            out_arg_perr <= 1'b0;
            out_res_perr <= 1'b0;
            out_timeout  <= 1'b1;
            out_valid    <= 1'b1;
            req          <= 1'b0;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RESP: begin
          // Passing through RESP and IDLE guarantees req is low for at
          // least one cycle between requests.
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
